// File: rtl/regfile_mp_sb_pkg.sv
// Shared register-file constants and port-slice helpers, used by the regfile,
// pipeline decode and forwarding units.
`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_NUM_RD   = 2;
  localparam int RF_NUM_WR   = 2;
  localparam int RF_ZERO_REG = 1;
endpackage

`endif

// File: rtl/regfile_mp_sb_if.sv
// Register-file bus: decode read/issue side plus writeback side.
// master = pipeline, slave = register file.
interface regfile_mp_sb_if #(
  parameter int DATA_W = regfile_pkg::RF_DATA_W,
  parameter int ADDR_W = regfile_pkg::RF_ADDR_W,
  parameter int NUM_RD = regfile_pkg::RF_NUM_RD,
  parameter int NUM_WR = regfile_pkg::RF_NUM_WR
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [2**ADDR_W-1:0]     busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Pending-write scoreboard: one busy flop per register, issue-set beats
// writeback-clear so a newer producer stays visible.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en) set_vec[iss_addr] = 1'b1;
    if (ZERO_REG != 0) set_vec[0] = 1'b0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) clr_vec[`RF_SLICE(wr_addr, j, ADDR_W)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= set_vec | (busy_vec & ~clr_vec);
  end
endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with pending-write scoreboard.
// Optional same-cycle write-through enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb import regfile_pkg::*; #(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int NUM_WR   = RF_NUM_WR,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] &&
            !(ZERO_REG != 0 && `RF_SLICE(bus.wr_addr, j, ADDR_W) == '0))
          mem[`RF_SLICE(bus.wr_addr, j, ADDR_W)] <= `RF_SLICE(bus.wr_data, j, DATA_W);
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .busy_vec (bus.busy_vec)
  );

  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rdat;
  logic                     rbusy;
`ifdef REGFILE_BYPASS_EN
  logic                     hit;
`endif

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    rdat      = '0;
    rbusy     = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit       = 1'b0;
`endif
    for (int k = 0; k < NUM_RD; k++) begin
      ra    = `RF_SLICE(bus.rd_addr, k, ADDR_W);
      rdat  = mem[ra];
      rbusy = bus.busy_vec[ra];
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && `RF_SLICE(bus.wr_addr, j, ADDR_W) == ra) begin
          rdat = `RF_SLICE(bus.wr_data, j, DATA_W);
          hit  = 1'b1;
        end
      end
      // A same-cycle issue means a newer producer is in flight; keep busy.
      if (hit && !(bus.iss_en && bus.iss_addr == ra)) rbusy = 1'b0;
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
      rd_data_c[k*DATA_W +: DATA_W] = rdat;
      rd_busy_c[k]                  = rbusy;
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb (2 read, 2 write ports).
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.wr_en  = '0;
    bus.iss_en = 1'b0;
  endtask

  initial begin
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    #2;
    check("reset_rd_data",  64'(bus.rd_data),  64'h0);
    check("reset_rd_busy",  64'(bus.rd_busy),  64'h0);
    check("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // reset mid-run
    bus.rd_addr  = {5'd0, 5'd5};
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd5};
    bus.wr_data  = {32'h0, 32'hDEADBEEF};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd4;
    tick();
    check("r5_written",    64'(bus.rd_data[31:0]), 64'hDEADBEEF);
    check("r4_busy_set",   64'(bus.busy_vec),      64'h10);
    #2 rst = 1'b0;
    #1;
    check("midrst_r5",       64'(bus.rd_data[31:0]), 64'h0);
    check("midrst_busy_vec", 64'(bus.busy_vec),      64'h0);
    check("midrst_rd_busy",  64'(bus.rd_busy),       64'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en   = 2'b10;
    bus.wr_addr = {5'd6, 5'd0};
    bus.wr_data = {32'h1234, 32'h0};
    bus.rd_addr = {5'd6, 5'd5};
    tick();
    check("post_rst_r6", 64'(bus.rd_data[63:32]), 64'h1234);
    check("post_rst_r5", 64'(bus.rd_data[31:0]),  64'h0);

    // dual write conflict
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {32'h22, 32'h11};
    bus.rd_addr = {5'd7, 5'd7};
    tick();
    check("conflict_p0", 64'(bus.rd_data[31:0]),  64'h22);
    check("conflict_p1", 64'(bus.rd_data[63:32]), 64'h22);
    bus.wr_en   = 2'b11;
    bus.wr_addr = {5'd7, 5'd8};
    bus.wr_data = {32'h33, 32'hAA};
    bus.rd_addr = {5'd8, 5'd7};
    tick();
    check("dual_r7", 64'(bus.rd_data[31:0]),  64'h33);
    check("dual_r8", 64'(bus.rd_data[63:32]), 64'hAA);

    // scoreboard set / clear
    bus.rd_addr  = {5'd0, 5'd3};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    tick();
    check("iss_r3_rd_busy",  64'(bus.rd_busy),  64'h1);
    check("iss_r3_busy_vec", 64'(bus.busy_vec), 64'h8);
    bus.wr_en   = 2'b10;
    bus.wr_addr = {5'd3, 5'd0};
    bus.wr_data = {32'h55, 32'h0};
    tick();
    check("wb_r3_rd_busy",  64'(bus.rd_busy),       64'h0);
    check("wb_r3_data",     64'(bus.rd_data[31:0]), 64'h55);
    check("wb_r3_busy_vec", 64'(bus.busy_vec),      64'h0);

    // issue + writeback same edge: set wins, data still written
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd3;
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd3};
    bus.wr_data  = {32'h0, 32'h66};
    tick();
    check("isswb_rd_busy",  64'(bus.rd_busy[0]),    64'h1);
    check("isswb_data",     64'(bus.rd_data[31:0]), 64'h66);
    tick();
    check("isswb_hold",     64'(bus.busy_vec),      64'h8);
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd3};
    bus.wr_data = {32'h0, 32'h77};
    tick();
    check("r3_clear",       64'(bus.busy_vec),      64'h0);

    // zero register
    bus.rd_addr  = {5'd0, 5'd0};
    bus.wr_en    = 2'b11;
    bus.wr_addr  = {5'd0, 5'd0};
    bus.wr_data  = {32'hFFFFFFFF, 32'hFFFFFFFF};
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd0;
    #1;
    check("r0_same_cycle_data", 64'(bus.rd_data), 64'h0);
    check("r0_same_cycle_busy", 64'(bus.rd_busy), 64'h0);
    tick();
    check("r0_data",     64'(bus.rd_data),  64'h0);
    check("r0_busy_vec", 64'(bus.busy_vec), 64'h0);

    // bypass / write-through
    bus.rd_addr = {5'd9, 5'd0};
    bus.wr_en   = 2'b01;
    bus.wr_addr = {5'd0, 5'd9};
    bus.wr_data = {32'h0, 32'h1111};
    tick();
    check("r9_init", 64'(bus.rd_data[63:32]), 64'h1111);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    tick();
    check("r9_busy", 64'(bus.rd_busy), 64'h2);
    bus.wr_en   = 2'b10;
    bus.wr_addr = {5'd9, 5'd0};
    bus.wr_data = {32'hCAFE, 32'h0};
    #1;
    check("byp_data", 64'(bus.rd_data[63:32]), BYP ? 64'hCAFE : 64'h1111);
    check("byp_busy", 64'(bus.rd_busy[1]),     BYP ? 64'h0 : 64'h1);
    tick();
    check("r9_cafe",      64'(bus.rd_data[63:32]), 64'hCAFE);
    check("r9_busy_clr",  64'(bus.rd_busy),        64'h0);
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    tick();
    bus.iss_en   = 1'b1;
    bus.iss_addr = 5'd9;
    bus.wr_en    = 2'b01;
    bus.wr_addr  = {5'd0, 5'd9};
    bus.wr_data  = {32'h0, 32'hBEEF};
    #1;
    check("byp_iss_data", 64'(bus.rd_data[63:32]), BYP ? 64'hBEEF : 64'hCAFE);
    check("byp_iss_busy", 64'(bus.rd_busy[1]),     64'h1);
    tick();
    check("r9_beef",      64'(bus.rd_data[63:32]), 64'hBEEF);
    check("r9_still_busy", 64'(bus.busy_vec),      64'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
